// File: rtl/demux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// demux_scan_ctrl
//
// Upstream sequencer for the 1x16 demultiplexer stage. A 16-bit word is taken
// in through a valid/ready handshake and then scanned out one bit per clock:
// during the slot for channel n the block drives the demux data input `a` with
// bit n of the word and the channel select {s3,s2,s1,s0} with n, so the bit
// lands on demux output y[n]. Frame status is reported through `busy` and a
// one-cycle `frame_done` pulse.
//
// Ports
//   clk         in   1   rising-edge clock
//   rst         in   1   asynchronous, active-high reset
//   in_data     in   16  word to scan, bit n goes to channel n
//   in_valid    in   1   in_data is valid
//   in_ready    out  1   block can accept a word this cycle (state IDLE)
//   a           out  1   demux data input (registered)
//   s0..s3      out  1   demux channel select, s3 is the MSB (registered)
//   strobe      out  1   a / s3..s0 carry a live scan slot this cycle
//   busy        out  1   frame in progress (state SCAN)
//   frame_done  out  1   one-cycle pulse in the cycle after a frame's last slot
//
// Build option
//   DEMUX_SCAN_SKIP_ZERO_EN  when defined, zero bits get no scan slot: only
//                            channels whose bit is set are strobed (with a=1),
//                            and an all-zero word finishes immediately with a
//                            frame_done pulse and no strobe.
//
// Handshake: a word is transferred on a rising edge where in_valid and
// in_ready are both high. in_ready depends on state only, never on in_valid,
// and in_data/in_valid are ignored while in_ready is low. in_valid may drop at
// any time without consequence; each accepted word is scanned exactly once.
// -----------------------------------------------------------------------------
module demux_scan_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        a,
    output logic        s0,
    output logic        s1,
    output logic        s2,
    output logic        s3,
    output logic        strobe,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] word_q;     // captured word (skip-zero: bits still to scan)
    logic [3:0]  idx;        // channel of the current slot
    logic        a_q;        // registered demux data bit
    logic        done_q;     // frame_done pulse register

    logic        accept;     // handshake completes on this edge
    logic        last_slot;  // current slot is the final one of the frame

    assign accept = in_valid && (state == IDLE);

`ifdef DEMUX_SCAN_SKIP_ZERO_EN
    logic [15:0] word_clr;   // word with the current slot's bit retired

    // Index of the lowest set bit; 0 for an all-zero word.
    function automatic logic [3:0] lowest_set(input logic [15:0] w);
        lowest_set = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w[i]) begin
                lowest_set = 4'(i);
            end
        end
    endfunction

    assign word_clr  = word_q & ~(16'd1 << idx);
    // The frame ends once the slot being shown was the highest set bit.
    assign last_slot = (word_clr == 16'd0);
`else
    logic [3:0]  idx_inc;

    assign idx_inc   = idx + 4'd1;
    // Channel 15 is the only way out of SCAN; idx never wraps in a frame.
    assign last_slot = (idx == 4'd15);
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef DEMUX_SCAN_SKIP_ZERO_EN
                    // An empty word has nothing to scan and stays in IDLE.
                    if (in_data != 16'd0) begin
                        state_next = SCAN;
                    end
`else
                    state_next = SCAN;
`endif
                end
            end
            SCAN: begin
                if (last_slot) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: word capture, slot index, data bit and frame_done pulse.
    // a_q and idx are loaded one edge ahead so that they already hold the
    // values of the slot being entered.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= 16'd0;
            idx    <= 4'd0;
            a_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        word_q <= in_data;
`ifdef DEMUX_SCAN_SKIP_ZERO_EN
                        if (in_data == 16'd0) begin
                            idx    <= 4'd0;
                            a_q    <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            idx <= lowest_set(in_data);
                            a_q <= 1'b1;
                        end
`else
                        idx <= 4'd0;
                        a_q <= in_data[0];
`endif
                    end
                end
                SCAN: begin
                    if (last_slot) begin
                        // Back to IDLE with select and data at zero.
                        idx    <= 4'd0;
                        a_q    <= 1'b0;
                        done_q <= 1'b1;
`ifdef DEMUX_SCAN_SKIP_ZERO_EN
                        word_q <= word_clr;
`endif
                    end else begin
`ifdef DEMUX_SCAN_SKIP_ZERO_EN
                        word_q <= word_clr;
                        idx    <= lowest_set(word_clr);
                        a_q    <= 1'b1;
`else
                        idx    <= idx_inc;
                        a_q    <= word_q[idx_inc];
`endif
                    end
                end
                default: begin
                    idx <= 4'd0;
                    a_q <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: registers or pure state decode, no path from in_valid/in_data.
    // -------------------------------------------------------------------------
    assign in_ready   = (state == IDLE);
    assign busy       = (state == SCAN);
    assign strobe     = (state == SCAN);
    assign a          = a_q;
    assign s0         = idx[0];
    assign s1         = idx[1];
    assign s2         = idx[2];
    assign s3         = idx[3];
    assign frame_done = done_q;

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_demux_scan_ctrl
//
// Directed bench for demux_scan_ctrl. Every cycle's expected output vector
// {in_ready, busy, strobe, s3, s2, s1, s0, a, frame_done} is pushed into
// exp_q when a word is driven, and popped/compared at the falling edge while
// the DUT plays the frame out. Works for both the default and the
// DEMUX_SCAN_SKIP_ZERO_EN build.
// -----------------------------------------------------------------------------
module tb_demux_scan_ctrl;

    // ---------------------------------------------------------------- clock/reset
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic        in_valid = 1'b0;

    logic        in_ready;
    logic        a;
    logic        s0;
    logic        s1;
    logic        s2;
    logic        s3;
    logic        strobe;
    logic        busy;
    logic        frame_done;

    always #5 clk = ~clk;

    demux_scan_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .s0         (s0),
        .s1         (s1),
        .s2         (s2),
        .s3         (s3),
        .strobe     (strobe),
        .busy       (busy),
        .frame_done (frame_done)
    );

    logic [8:0] obs;
    assign obs = {in_ready, busy, strobe, s3, s2, s1, s0, a, frame_done};

    localparam logic [8:0] IDLE_V = 9'b1_0_0_0000_0_0;
    localparam logic [8:0] DONE_V = 9'b1_0_0_0000_0_1;

    // ---------------------------------------------------------------- scoreboard
    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] frame_buf[17];
    int         frame_len;

    function automatic logic [8:0] slot_v(input int n, input logic bit_a);
        logic [3:0] sel;
        sel = 4'(n);
        return {1'b0, 1'b1, 1'b1, sel, bit_a, 1'b0};
    endfunction

    // Reference frame for a word: its slots followed by the frame_done cycle.
    task automatic build_frame(input logic [15:0] w);
        frame_len = 0;
        for (int i = 0; i < 16; i++) begin
`ifdef DEMUX_SCAN_SKIP_ZERO_EN
            if (w[i]) begin
                frame_buf[frame_len] = slot_v(i, 1'b1);
                frame_len++;
            end
`else
            frame_buf[frame_len] = slot_v(i, w[i]);
            frame_len++;
`endif
        end
        frame_buf[frame_len] = DONE_V;
        frame_len++;
    endtask

    task automatic push_frame(input logic [15:0] w);
        build_frame(w);
        for (int i = 0; i < frame_len; i++) exp_q.push_back(frame_buf[i]);
    endtask

    task automatic push_head(input logic [15:0] w, input int n);
        build_frame(w);
        for (int i = 0; i < n && i < frame_len; i++) exp_q.push_back(frame_buf[i]);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(IDLE_V);
    endtask

    task automatic check(input string tag, input logic [8:0] o, input logic [8:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic check_pop(input string tag);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%b expected=<empty queue>", tag, obs);
        end else begin
            check(tag, obs, exp_q.pop_front());
        end
    endtask

    // Compare one queued vector per cycle, moving to the next falling edge.
    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            check_pop(tag);
            @(negedge clk);
        end
    endtask

    task automatic drain_n(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check_pop(tag);
            @(negedge clk);
        end
    endtask

    // Present a word for one edge, then drop in_valid.
    task automatic send_word(input logic [15:0] w);
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        // Asynchronous reset between clock edges.
        #1 rst = 1'b1;
        #2 check("reset_async", obs, IDLE_V);
        @(negedge clk);
        rst = 1'b0;
        push_idle(2);
        drain("idle_after_reset");

        // Single frame.
        send_word(16'hA5C3);
        push_frame(16'hA5C3);
        push_idle(2);
        drain("frame_a5c3");

        // Back-to-back with in_valid held high.
        in_data  = 16'hFFFF;
        in_valid = 1'b1;
        @(negedge clk);
        in_data  = 16'h0001;
        push_frame(16'hFFFF);
        push_frame(16'h0001);
        push_idle(2);
        build_frame(16'hFFFF);
        drain_n("b2b_first", frame_len);
        in_valid = 1'b0;
        drain("b2b_second");

        // Handshake hold-off: junk on the inputs while scanning.
        send_word(16'h1234);
        push_frame(16'h1234);
        push_idle(2);
        while (exp_q.size() > 3) begin
            check_pop("holdoff");
            in_data  = 16'($urandom_range(0, 65535));
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain("holdoff_tail");

        // Reset in the middle of a frame (during the eighth slot).
        send_word(16'h5A5A);
        push_head(16'h5A5A, 8);
        drain_n("midframe", 7);
        check_pop("midframe_slot7");
        #2 rst = 1'b1;
        #1 check("reset_midframe", obs, IDLE_V);
        @(negedge clk);
        rst = 1'b0;
        push_idle(3);
        drain("no_done_after_abort");
        send_word(16'h0F0F);
        push_frame(16'h0F0F);
        push_idle(1);
        drain("frame_after_abort");

        // Sparse and empty words (slots skipped in the skip-zero build).
        send_word(16'h8011);
        push_frame(16'h8011);
        push_idle(1);
        drain("frame_8011");
        send_word(16'h0000);
        push_frame(16'h0000);
        push_idle(2);
        drain("frame_0000");

        // A few random words.
        for (int k = 0; k < 3; k++) begin
            logic [15:0] w;
            w = 16'($urandom_range(0, 65535));
            send_word(w);
            push_frame(w);
            push_idle(1);
            drain("frame_random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_scan_ctrl.md
# demux_scan_ctrl

Upstream sequencer for the 1x16 demultiplexer stage. Accepts a 16-bit parallel word through a valid/ready handshake and serialises it over 16 clock cycles. For each bit it drives the demux data input `a` and the channel select `s3..s0`, so bit *n* of the word appears on demux output `y[n]` during its scan slot. It provides frame status (`busy`, `frame_done`) to the surrounding control logic.

## Interface
- No parameters. Width is fixed at 16 channels and 4 select bits to match the demux.
- `clk`  input  1  — single clock; all state updates on the rising edge.
- `rst`  input  1  — asynchronous, active-high reset.
- `in_data`  input  16  — word to scan; bit *n* is routed to channel *n*.
- `in_valid`  input  1  — `in_data` is valid.
- `in_ready`  output  1  — block can accept a word this cycle.
- `a`  output  1  — demux data input (registered).
- `s0`, `s1`, `s2`, `s3`  output  1 each  — demux select, `s3` is MSB (registered).
- `strobe`  output  1  — `a` and `s3..s0` hold a live scan slot this cycle.
- `busy`  output  1  — frame in progress (state SCAN).
- `frame_done`  output  1  — one-cycle pulse after the last slot of a frame.

## Operation
- **States:** IDLE, SCAN.
- **Registers:**
  - `word_q[15:0]`: captured word.
  - `idx[3:0]`: current channel.
  - `frame_done` pulse register.
- **IDLE:**
  - `in_ready=1`; `strobe=0`, `a=0`, `s3..s0=0`, `busy=0`.
  - With `strobe=0` and `a=0`, all demux outputs are 0.
- **Accept:** `in_valid & in_ready` at a rising edge.
  - Capture `in_data` into `word_q`.
  - Set `idx=0` and go to SCAN.
- **SCAN:**
  - `in_ready=0`, `busy=1`, `strobe=1`.
  - `{s3,s2,s1,s0}=idx`, `a=word_q[idx]`.
  - Each edge: `idx` increments.
  - When `idx==15`, the edge returns to IDLE and sets `frame_done` for exactly the following cycle.
- **Handshake rules:**
  - `in_data` is ignored while `in_ready=0`.
  - `in_valid` may drop without penalty.
  - No word is lost or duplicated.
- **Back-to-back frames:** the `frame_done` cycle is an IDLE cycle with `in_ready=1`. An accept in that cycle starts the next SCAN on the following edge.
- **Reset mid-frame:** the frame is aborted immediately.
  - All outputs go to their reset values; `frame_done` is not pulsed.
  - The aborted word is discarded.
- **Select wrap:** `idx` never wraps inside a frame. Leaving SCAN at `idx==15` is the only exit.

## Timing
- Reset values: state=IDLE, `in_ready=1`, `a=0`, `s3..s0=0`, `strobe=0`, `busy=0`, `frame_done=0`, `word_q=0`, `idx=0`.
- All outputs are registered or decoded from state only. There is no combinational path from `in_valid`/`in_data` to any output.
- Latency: accept edge → first slot (channel 0) is valid in the next cycle.
- Slot *n* occupies cycle *n+1* after the accept edge.
- `frame_done` is high in cycle 17.
- Sustained throughput with `in_valid` held high: one frame per 17 cycles.

## Configuration
- Macro: `DEMUX_SCAN_SKIP_ZERO_EN`.
- **Undefined (default):** behaviour is exactly as above; every frame has 16 slots.
- **Defined:** zero bits get no slot.
  - On accept, `idx` loads the index of the lowest set bit of `in_data`.
  - Each SCAN edge clears `word_q[idx]` and moves `idx` to the next higher set bit.
  - SCAN exits after the highest set bit's slot.
  - `a=1` in every slot. The number of slots equals popcount(`in_data`).
  - Accepting `16'h0000`: the block stays IDLE and pulses `frame_done` in the next cycle, with no strobe.
  - Handshake, reset and `frame_done` rules are otherwise unchanged.

## Test plan
- **Reset:** assert `rst` asynchronously between edges → all outputs at reset values immediately.
  - After release, `in_ready=1`.
- **Single frame:** accept `in_data=16'hA5C3` (default build) → cycles 1–16 show `strobe=1`, select 0..15, and `a` equal to bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - `frame_done` is high in cycle 17 only.
- **Back-to-back:** `in_valid` held high with words `16'hFFFF` then `16'h0001` → second frame's slot 0 starts in cycle 18.
  - There is no gap slot and `frame_done` pulses twice.
- **Handshake hold-off:** change `in_data` and toggle `in_valid` during SCAN → current frame unaffected.
  - No accept occurs until IDLE.
- **Reset mid-frame:** assert `rst` at slot 7 → outputs zero at once, no `frame_done`.
  - A new word is accepted normally after release.
- **Skip-zero build:**
  - Accept `16'h8011` → 3 slots with select 0, 4, 15, each with `a=1`; `frame_done` in cycle 4.
  - Accept `16'h0000` → no strobe and `frame_done` in cycle 1.
